dual_ram_pass_scheduler: RTL and testbench
==========================================

// Module: dual_ram_pass_scheduler
// PURPOSE
//  Sequences the two-RAM sum/difference datapath. Port A of both RAMs reads and
//  port B writes back (RAM0 <= a+b, RAM1 <= a-b). Runs one pass over a programmable
//  address range per start request. Also arbitrates port B between the pass engine
//  and an external loader that initialises RAM contents; one owner at a time.
// PARAMETERS
//  ADDR_W  9  address width of both RAMs; depth = 2**ADDR_W
// PORTS
//  CLOCK_50_I    in   1       system clock, all state on rising edge
//  resetn        in   1       asynchronous, active-low reset
//  start_i       in   1       pass request, sampled each cycle
//  start_addr_i  in   ADDR_W  first address of pass, captured when pass launches
//  end_addr_i    in   ADDR_W  last address of pass, captured when pass launches
//  ld_req_i      in   1       loader requests port B, level, held until finished
//  ld_addr_i     in   ADDR_W  loader write address, valid while ld_gnt_o=1
//  ld_wen_i      in   2       loader write enables {RAM1,RAM0}, valid while ld_gnt_o=1
//  ld_gnt_o      out  1       port B granted to loader (registered)
//  rd_addr_o     out  ADDR_W  port A address, both RAMs (registered)
//  wr_addr_o     out  ADDR_W  port B address, both RAMs
//  wen_b_o       out  2       port B write enables {RAM1,RAM0}; port A never writes
//  wr_sel_o      out  1       port B data mux: 0=sum/diff datapath, 1=loader data
//  busy_o        out  1       pass in progress (S_READ_WRITE or S_LAST_WRITE)
//  done_o        out  1       one-cycle pulse, cycle after the last write
// BEHAVIOUR
//  Reset: state S_IDLE. rd_addr_o, wr_addr_o = 0. wen_b_o = 00.
//   ld_gnt_o, wr_sel_o, busy_o, done_o, pending flag = 0. Effective immediately.
//  RAM read latency is 1 cycle: q_a for rd_addr at cycle n is valid in n+1. That word
//   is written at wr_addr = previous rd_addr in cycle n+1.
//  S_IDLE:
//   - ld_req_i=1: go to S_LOAD, ld_gnt_o<=1. This has priority.
//   - If start_i=1 in the same cycle, set pending. Start is not lost.
//   - Else if start_i or pending: capture start/end, rd_addr<=start_addr_i,
//     clear pending, go to S_READ_WRITE.
//  S_READ_WRITE, every cycle:
//   - rd_addr<=rd_addr+1, mod 2**ADDR_W (wraps 511->0).
//   - wr_addr<=rd_addr; wen_b<=11, so writes start the 2nd cycle of the pass.
//   - When rd_addr==end_q, go to S_LAST_WRITE.
//  S_LAST_WRITE: the last word is written this cycle. Then wen_b<=00,
//   rd_addr<=0, wr_addr<=0, done_o<=1 for one cycle, go to S_IDLE.
//  S_LOAD:
//   - wr_addr_o=ld_addr_i and wen_b_o=ld_wen_i (combinational, gated by state);
//     wr_sel_o=1. rd_addr_o held.
//   - start_i here sets pending.
//   - ld_req_i=0: ld_gnt_o<=0, go to S_IDLE. A pending pass launches from S_IDLE next cycle.
//  Range: pass length N = (end-start) mod 2**ADDR_W + 1.
//   - end<start wraps through the top address.
//   - end==start gives a single-word pass (wen_b high exactly 1 cycle).
//   - start==end+1 covers the full depth.
//  Timing: start accepted at edge e0; writes occur in cycles e1+1..e1+N.
//   busy_o high N+1 cycles; done_o in cycle N+2.
//  No preemption: ld_req_i during a pass waits until S_IDLE. start_i during a pass
//   is ignored and not pended.
//  Reset mid-pass: abort, all outputs to reset values. The partial pass is not resumed;
//   already-written words stay in RAM.
// CONFIGURATION
//  PASS_COUNT_EN defined:
//   - adds output pass_cnt_o [15:0], reset 0.
//   - +1 on each done_o pulse, saturates at 16'hFFFF.
//  PASS_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. start=0,end=511, RAM0[i]=i, RAM1[i]=1:
//     -> 512 writes, addr 0..511; RAM0[i]=i+1, RAM1[i]=i-1 (8b wrap);
//     done_o at cycle 514 after start edge.
//  2. start=510,end=1 -> writes 510,511,0,1 in order; wen_b=11 exactly 4 cycles; done once.
//  3. start=end=7 -> single write to addr 7; other addresses untouched; busy_o 2 cycles.
//  4. start_i and ld_req_i together in S_IDLE:
//     -> ld_gnt_o=1 next cycle; loader writes addr 3 wen=01 with wr_sel_o=1;
//     drop req -> gnt 0, then pass launches.
//  5. ld_req_i raised mid-pass (rd_addr=200, end=300):
//     -> ld_gnt_o stays 0 until after done_o; pass writes all 101 words.
//  6. resetn low at rd_addr=100:
//     -> wen_b_o=00, busy_o=0 immediately; after release a fresh start runs a complete pass.
//     With PASS_COUNT_EN: count not incremented for the aborted pass.

Source files
------------

// File: rtl/dual_ram_pass_scheduler.sv
// Pass sequencer for the two-RAM sum/difference datapath, with port-B arbitration
// against an external loader. Optional pass counter enabled by defining PASS_COUNT_EN.
module dual_ram_pass_scheduler #(
    parameter int ADDR_W = 9
) (
    input  logic              CLOCK_50_I,
    input  logic              resetn,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W-1:0] end_addr_i,
    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [1:0]        ld_wen_i,
    output logic              ld_gnt_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [1:0]        wen_b_o,
    output logic              wr_sel_o,
    output logic              busy_o,
    output logic              done_o
`ifdef PASS_COUNT_EN
    ,
    output logic [15:0]       pass_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ_WRITE,
        S_LAST_WRITE,
        S_LOAD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [1:0]        wen_q, wen_d;
    logic              gnt_q, gnt_d;
    logic              done_q, done_d;
    logic              pending_q, pending_d;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            end_q     <= '0;
            wen_q     <= 2'b00;
            gnt_q     <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            end_q     <= end_d;
            wen_q     <= wen_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            pending_q <= pending_d;
        end
    end

    // The write address trails the read address by one cycle to cover the RAM read latency.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        end_d     = end_q;
        wen_d     = wen_q;
        gnt_d     = gnt_q;
        done_d    = 1'b0;
        pending_d = pending_q;
        case (state_q)
            S_IDLE: begin
                if (ld_req_i) begin
                    state_d = S_LOAD;
                    gnt_d   = 1'b1;
                    if (start_i) pending_d = 1'b1;
                end else if (start_i || pending_q) begin
                    end_d     = end_addr_i;
                    rd_addr_d = start_addr_i;
                    pending_d = 1'b0;
                    state_d   = S_READ_WRITE;
                end
            end
            S_READ_WRITE: begin
                rd_addr_d = rd_addr_q + ADDR_W'(1);
                wr_addr_d = rd_addr_q;
                wen_d     = 2'b11;
                if (rd_addr_q == end_q) state_d = S_LAST_WRITE;
            end
            S_LAST_WRITE: begin
                wen_d     = 2'b00;
                rd_addr_d = '0;
                wr_addr_d = '0;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            S_LOAD: begin
                if (start_i) pending_d = 1'b1;
                if (!ld_req_i) begin
                    gnt_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // While the loader owns port B its address and enables pass straight through.
    assign wr_addr_o = (state_q == S_LOAD) ? ld_addr_i : wr_addr_q;
    assign wen_b_o   = (state_q == S_LOAD) ? ld_wen_i  : wen_q;
    assign wr_sel_o  = (state_q == S_LOAD);
    assign busy_o    = (state_q == S_READ_WRITE) || (state_q == S_LAST_WRITE);
    assign rd_addr_o = rd_addr_q;
    assign ld_gnt_o  = gnt_q;
    assign done_o    = done_q;

`ifdef PASS_COUNT_EN
    logic [15:0] pass_cnt_q;

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            pass_cnt_q <= 16'd0;
        end else if (done_q && (pass_cnt_q != 16'hFFFF)) begin
            pass_cnt_q <= pass_cnt_q + 16'd1;
        end
    end

    assign pass_cnt_o = pass_cnt_q;
`endif

endmodule

// File: tb/tb_dual_ram_pass_scheduler.sv
// Self-checking bench for dual_ram_pass_scheduler: behavioural RAM pair plus datapath,
// table of passes and hand-written loader/preemption/reset sequences.
module tb_dual_ram_pass_scheduler;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start_i = 1'b0;
    logic [8:0] start_addr_i = '0;
    logic [8:0] end_addr_i = '0;
    logic       ld_req_i = 1'b0;
    logic [8:0] ld_addr_i = '0;
    logic [1:0] ld_wen_i = 2'b00;
    logic       ld_gnt_o;
    logic [8:0] rd_addr_o;
    logic [8:0] wr_addr_o;
    logic [1:0] wen_b_o;
    logic       wr_sel_o;
    logic       busy_o;
    logic       done_o;
`ifdef PASS_COUNT_EN
    logic [15:0] pass_cnt;
`endif

    dual_ram_pass_scheduler #(.ADDR_W(9)) dut (
        .CLOCK_50_I  (clk),
        .resetn      (resetn),
        .start_i     (start_i),
        .start_addr_i(start_addr_i),
        .end_addr_i  (end_addr_i),
        .ld_req_i    (ld_req_i),
        .ld_addr_i   (ld_addr_i),
        .ld_wen_i    (ld_wen_i),
        .ld_gnt_o    (ld_gnt_o),
        .rd_addr_o   (rd_addr_o),
        .wr_addr_o   (wr_addr_o),
        .wen_b_o     (wen_b_o),
        .wr_sel_o    (wr_sel_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef PASS_COUNT_EN
        ,
        .pass_cnt_o  (pass_cnt)
`endif
    );

    always #10 clk = ~clk;

    // Behavioural RAM pair: port A registered read, port B write of sum/diff or loader data.
    logic [7:0] ram0 [512];
    logic [7:0] ram1 [512];
    logic [7:0] q0, q1;
    logic [7:0] ld_data0 = 8'h00;
    logic [7:0] ld_data1 = 8'h00;
    logic       init_ram = 1'b0;

    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 512; i++) begin
                ram0[i] <= i[7:0];
                ram1[i] <= 8'd1;
            end
        end else begin
            q0 <= ram0[rd_addr_o];
            q1 <= ram1[rd_addr_o];
            if (wen_b_o[0]) ram0[wr_addr_o] <= wr_sel_o ? ld_data0 : q0 + q1;
            if (wen_b_o[1]) ram1[wr_addr_o] <= wr_sel_o ? ld_data1 : q0 - q1;
        end
    end

    typedef struct {
        logic [8:0] s;
        logic [8:0] e;
        int         n;
        string      tag;
    } vec_t;

    vec_t       vecs [5];
    int         tests = 0;
    int         fails = 0;
    int         exp_cnt = 0;
    logic [7:0] exp0 [512];
    logic [7:0] exp1 [512];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] s, input logic [8:0] e);
        @(negedge clk);
        start_addr_i = s;
        end_addr_i   = e;
        start_i      = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    // Runs one pass and checks write order, timing and resulting RAM contents.
    task automatic runPass(input logic [8:0] s, input logic [8:0] e, input int n,
                           input int req_at, input string tag);
        int         wr_cnt = 0, bad = 0, first_wr = 0, busy_cnt = 0;
        int         done_cnt = 0, done_cyc = 0, gnt_seen = 0, diffs = 0;
        logic [8:0] a;
        for (int i = 0; i < 512; i++) begin
            exp0[i] = ram0[i];
            exp1[i] = ram1[i];
        end
        for (int k = 0; k < n; k++) begin
            a = s + 9'(k);
            exp0[a] = ram0[a] + ram1[a];
            exp1[a] = ram0[a] - ram1[a];
        end
        applyStimulus(s, e);
        for (int k = 1; k < 1200; k++) begin
            @(negedge clk);
            if (wen_b_o != 2'b00) begin
                a = s + 9'(wr_cnt);
                wr_cnt++;
                if (first_wr == 0) first_wr = k;
                if (wen_b_o != 2'b11 || wr_addr_o != a) bad++;
            end
            if (busy_o) busy_cnt++;
            if (ld_gnt_o && (done_cyc == 0 || k == done_cyc)) gnt_seen++;
            if (done_o) begin
                done_cnt++;
                done_cyc = k;
            end
            if (k == req_at) ld_req_i = 1'b1;
            if (done_cyc != 0 && k == done_cyc + 1) break;
        end
        for (int i = 0; i < 512; i++)
            if (exp0[i] !== ram0[i] || exp1[i] !== ram1[i]) diffs++;
        checkOutput({tag, "_writes"}, wr_cnt, n);
        checkOutput({tag, "_wr_order"}, bad, 0);
        checkOutput({tag, "_first_wr_cycle"}, first_wr, 2);
        checkOutput({tag, "_busy_cycles"}, busy_cnt, n + 1);
        checkOutput({tag, "_done_cycle"}, done_cyc, n + 2);
        checkOutput({tag, "_done_pulses"}, done_cnt, 1);
        checkOutput({tag, "_gnt_during_pass"}, gnt_seen, 0);
        checkOutput({tag, "_ram_diffs"}, diffs, 0);
        exp_cnt++;
`ifdef PASS_COUNT_EN
        checkOutput({tag, "_pass_cnt"}, pass_cnt, exp_cnt);
`endif
    endtask

    initial begin
        logic [7:0] r1;
        int         found;

        vecs[0] = '{9'd0,   9'd511, 512, "full_0_511"};
        vecs[1] = '{9'd510, 9'd1,   4,   "wrap_510_1"};
        vecs[2] = '{9'd7,   9'd7,   1,   "single_7"};
        vecs[3] = '{9'd20,  9'd19,  512, "full_wrap_20_19"};
        vecs[4] = '{9'd100, 9'd102, 3,   "short_100_102"};

        init_ram = 1'b1;
        repeat (3) @(negedge clk);
        init_ram = 1'b0;
        checkOutput("rst_rd_addr", rd_addr_o, 0);
        checkOutput("rst_wr_addr", wr_addr_o, 0);
        checkOutput("rst_wen_b", wen_b_o, 0);
        checkOutput("rst_gnt", ld_gnt_o, 0);
        checkOutput("rst_wr_sel", wr_sel_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        resetn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            runPass(vecs[v].s, vecs[v].e, vecs[v].n, 0, vecs[v].tag);
            if (v == 0) begin
                checkOutput("full_ram0_511", ram0[511], 8'h00);
                checkOutput("full_ram0_9", ram0[9], 8'h0A);
                checkOutput("full_ram1_0", ram1[0], 8'hFF);
                checkOutput("full_ram1_300", ram1[300], 8'h2B);
            end
        end

        // Start and loader request together: loader wins, start is pended.
        @(negedge clk);
        r1 = ram1[3];
        start_addr_i = 9'd3;
        end_addr_i   = 9'd3;
        start_i      = 1'b1;
        ld_req_i     = 1'b1;
        ld_addr_i    = 9'd3;
        ld_wen_i     = 2'b01;
        ld_data0     = 8'hAB;
        @(negedge clk);
        start_i = 1'b0;
        checkOutput("ld_gnt", ld_gnt_o, 1);
        checkOutput("ld_wr_sel", wr_sel_o, 1);
        checkOutput("ld_wr_addr", wr_addr_o, 3);
        checkOutput("ld_wen", wen_b_o, 2'b01);
        checkOutput("ld_busy", busy_o, 0);
        ld_req_i = 1'b0;
        @(negedge clk);
        ld_wen_i = 2'b00;
        checkOutput("ld_gnt_drop", ld_gnt_o, 0);
        checkOutput("ld_wen_after", wen_b_o, 2'b00);
        checkOutput("ld_ram0_3", ram0[3], 8'hAB);
        @(negedge clk);
        checkOutput("pend_busy", busy_o, 1);
        checkOutput("pend_rd_addr", rd_addr_o, 3);
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            if (done_o) found = 1;
        end
        checkOutput("pend_done", found, 1);
        checkOutput("pend_ram0_3", ram0[3], 8'hAB + r1);
        exp_cnt++;

        // Loader request raised mid-pass waits for the pass to finish.
        runPass(9'd200, 9'd300, 101, 5, "noprempt_200_300");
        checkOutput("noprempt_gnt_after", ld_gnt_o, 1);
        ld_req_i = 1'b0;
        @(negedge clk);
        checkOutput("noprempt_gnt_drop", ld_gnt_o, 0);

        // Reset in the middle of a pass aborts it.
        applyStimulus(9'd90, 9'd200);
        found = 0;
        for (int k = 0; k < 300 && found == 0; k++) begin
            @(negedge clk);
            if (rd_addr_o == 9'd100) found = 1;
        end
        checkOutput("abort_reach_100", found, 1);
        resetn = 1'b0;
        #1;
        checkOutput("abort_wen_b", wen_b_o, 2'b00);
        checkOutput("abort_busy", busy_o, 0);
        checkOutput("abort_rd_addr", rd_addr_o, 0);
        checkOutput("abort_done", done_o, 0);
        exp_cnt = 0;
`ifdef PASS_COUNT_EN
        checkOutput("abort_pass_cnt", pass_cnt, 0);
`endif
        @(negedge clk);
        resetn = 1'b1;
        runPass(9'd0, 9'd5, 6, 0, "after_abort_0_5");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
